// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ID/EX issue stage: ALU control decode, operand b select, skid-buffered valid/ready output
module alu_issue_stage #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            alu_op,
  input  logic [2:0]            funct3,
  input  logic                  funct7_5,
  input  logic                  alu_src,
  input  logic [XLEN-1:0]       rs1_data,
  input  logic [XLEN-1:0]       rs2_data,
  input  logic [XLEN-1:0]       imm,
  input  logic [REG_ADDR_W-1:0] rd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       a,
  output logic [XLEN-1:0]       b,
  output logic [3:0]            alu_control_signal,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  illegal
);

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_XOR = 4'b0100;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_ILL = 4'b1111;

  logic [3:0]            dec_ctl;
  logic                  dec_ill;
  logic [XLEN-1:0]       dec_b;

  logic                  skid_valid;
  logic [XLEN-1:0]       skid_a;
  logic [XLEN-1:0]       skid_b;
  logic [3:0]            skid_ctl;
  logic [REG_ADDR_W-1:0] skid_rd;
  logic                  skid_ill;

  logic                  accept;
  logic                  out_free;

  // Anything not explicitly decoded falls through to the illegal code.
  always_comb begin
    dec_ctl = CTL_ILL;
    dec_ill = 1'b1;
    case (alu_op)
      2'b00: begin dec_ctl = CTL_ADD; dec_ill = 1'b0; end
      2'b01: begin dec_ctl = CTL_SUB; dec_ill = 1'b0; end
      2'b10: begin
        case (funct3)
          3'b000:  begin dec_ctl = funct7_5 ? CTL_SUB : CTL_ADD; dec_ill = 1'b0; end
          3'b111:  begin dec_ctl = CTL_AND; dec_ill = 1'b0; end
          3'b110:  begin dec_ctl = CTL_OR;  dec_ill = 1'b0; end
          3'b100:  begin dec_ctl = CTL_XOR; dec_ill = 1'b0; end
          default: begin dec_ctl = CTL_ILL; dec_ill = 1'b1; end
        endcase
      end
      default: begin
        case (funct3)
          3'b000:  begin dec_ctl = CTL_ADD; dec_ill = 1'b0; end
          3'b100:  begin dec_ctl = CTL_XOR; dec_ill = 1'b0; end
          3'b110:  begin dec_ctl = CTL_OR;  dec_ill = 1'b0; end
          3'b111:  begin dec_ctl = CTL_AND; dec_ill = 1'b0; end
          default: begin dec_ctl = CTL_ILL; dec_ill = 1'b1; end
        endcase
      end
    endcase
  end

  assign dec_b    = alu_src ? imm : rs2_data;
  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid          <= 1'b0;
      a                  <= '0;
      b                  <= '0;
      alu_control_signal <= '0;
      rd_out             <= '0;
      illegal            <= 1'b0;
      skid_valid         <= 1'b0;
      skid_a             <= '0;
      skid_b             <= '0;
      skid_ctl           <= '0;
      skid_rd            <= '0;
      skid_ill           <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      // Skid drains first to keep FIFO order; in_ready is low while it is full.
      if (skid_valid) begin
        out_valid          <= 1'b1;
        a                  <= skid_a;
        b                  <= skid_b;
        alu_control_signal <= skid_ctl;
        rd_out             <= skid_rd;
        illegal            <= skid_ill;
        skid_valid         <= 1'b0;
      end else if (accept) begin
        out_valid          <= 1'b1;
        a                  <= rs1_data;
        b                  <= dec_b;
        alu_control_signal <= dec_ctl;
        rd_out             <= rd_in;
        illegal            <= dec_ill;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_a     <= rs1_data;
      skid_b     <= dec_b;
      skid_ctl   <= dec_ctl;
      skid_rd    <= rd_in;
      skid_ill   <= dec_ill;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - scoreboard bench for alu_issue_stage with directed decode/handshake vectors
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic        funct7_5, alu_src;
  logic [63:0] rs1_data, rs2_data, imm;
  logic [4:0]  rd_in;
  logic        out_valid, out_ready;
  logic [63:0] a, b;
  logic [3:0]  alu_control_signal;
  logic [4:0]  rd_out;
  logic        illegal;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  ctl;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_cur;
  exp_t got;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_issue_stage #(.XLEN(64), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .alu_src(alu_src),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .rd_in(rd_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .alu_control_signal(alu_control_signal),
    .rd_out(rd_out), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: pop on every output transfer, push on every accepted input.
  always @(negedge clk) begin
    if (reset || flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat_rd", {59'd0, rd_out}, 64'h1F);
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got out_valid=1 rd=%0d expected no beat", rd_out);
        end else begin
          got = exp_q.pop_front();
          chk("mon_a", a, got.a);
          chk("mon_b", b, got.b);
          chk("mon_ctl", {60'd0, alu_control_signal}, {60'd0, got.ctl});
          chk("mon_rd", {59'd0, rd_out}, {59'd0, got.rd});
          chk("mon_illegal", {63'd0, illegal}, {63'd0, got.ill});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(exp_cur);
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic f75,
                      input logic src, input logic [63:0] r1, input logic [63:0] r2,
                      input logic [63:0] im, input logic [4:0] rd,
                      input logic [63:0] e_b, input logic [3:0] e_ctl, input logic e_ill);
    int waited;
    alu_op = op; funct3 = f3; funct7_5 = f75; alu_src = src;
    rs1_data = r1; rs2_data = r2; imm = im; rd_in = rd;
    exp_cur = '{a: r1, b: e_b, ctl: e_ctl, rd: rd, ill: e_ill};
    in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 after %0d cycles expected 1", waited);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 2'b00; funct3 = 3'b000; funct7_5 = 1'b0; alu_src = 1'b0;
    rs1_data = '0; rs2_data = '0; imm = '0; rd_in = '0;
    exp_cur = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_a", a, 64'd0);
    chk("rst_b", b, 64'd0);
    chk("rst_ctl", {60'd0, alu_control_signal}, 64'd0);
    chk("rst_rd", {59'd0, rd_out}, 64'd0);
    chk("rst_illegal", {63'd0, illegal}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2'b10, 3'b000, 1'b1, 1'b0, 64'h10, 64'h3, 64'h0, 5'd5, 64'h3, 4'b0110, 1'b0);
    chk("latency_out_valid", {63'd0, out_valid}, 64'd1);
    chk("latency_ctl", {60'd0, alu_control_signal}, 64'h6);
    send(2'b11, 3'b100, 1'b0, 1'b1, 64'h22, 64'h5, 64'hFFFF_FFFF_FFFF_FF00, 5'd6,
         64'hFFFF_FFFF_FFFF_FF00, 4'b0100, 1'b0);
    send(2'b10, 3'b000, 1'b0, 1'b0, 64'h7, 64'h9, 64'h1, 5'd7, 64'h9, 4'b0010, 1'b0);
    send(2'b10, 3'b111, 1'b0, 1'b0, 64'hF0, 64'h0F, 64'h1, 5'd8, 64'h0F, 4'b0000, 1'b0);
    send(2'b10, 3'b110, 1'b1, 1'b0, 64'hA, 64'hB, 64'h1, 5'd9, 64'hB, 4'b0001, 1'b0);
    send(2'b10, 3'b100, 1'b0, 1'b1, 64'hC, 64'hD, 64'h44, 5'd10, 64'h44, 4'b0100, 1'b0);
    send(2'b10, 3'b001, 1'b0, 1'b0, 64'h1, 64'h2, 64'h3, 5'd11, 64'h2, 4'b1111, 1'b1);
    send(2'b00, 3'b101, 1'b1, 1'b1, 64'h100, 64'h2, 64'h8, 5'd12, 64'h8, 4'b0010, 1'b0);
    send(2'b01, 3'b001, 1'b0, 1'b0, 64'h5, 64'h5, 64'h8, 5'd13, 64'h5, 4'b0110, 1'b0);
    send(2'b11, 3'b000, 1'b1, 1'b1, 64'h5, 64'h6, 64'h7, 5'd14, 64'h7, 4'b0010, 1'b0);
    send(2'b11, 3'b101, 1'b0, 1'b1, 64'h5, 64'h6, 64'h7, 5'd15, 64'h7, 4'b1111, 1'b1);
    send(2'b11, 3'b111, 1'b0, 1'b1, 64'hFF, 64'h6, 64'h0F, 5'd16, 64'h0F, 4'b0000, 1'b0);
    repeat (2) @(posedge clk); #1;

    // Backpressure: second beat lands in the skid, outputs hold.
    out_ready = 1'b0;
    send(2'b10, 3'b000, 1'b0, 1'b0, 64'h11, 64'h1, 64'h0, 5'd1, 64'h1, 4'b0010, 1'b0);
    send(2'b10, 3'b110, 1'b0, 1'b0, 64'h12, 64'h2, 64'h0, 5'd2, 64'h2, 4'b0001, 1'b0);
    chk("skid_in_ready_low", {63'd0, in_ready}, 64'd0);
    chk("stall_rd_first", {59'd0, rd_out}, 64'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("hold_rd", {59'd0, rd_out}, 64'd1);
    chk("hold_a", a, 64'h11);
    chk("hold_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_rd1", {59'd0, rd_out}, 64'd1);
    @(negedge clk);
    chk("drain_rd2", {59'd0, rd_out}, 64'd2);
    chk("drain_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    chk("drain_empty", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;

    // Flush with output and skid full and a live input beat.
    out_ready = 1'b0;
    send(2'b00, 3'b000, 1'b0, 1'b0, 64'h31, 64'h3, 64'h0, 5'd3, 64'h3, 4'b0010, 1'b0);
    send(2'b00, 3'b000, 1'b0, 1'b0, 64'h41, 64'h4, 64'h0, 5'd4, 64'h4, 4'b0010, 1'b0);
    rd_in = 5'd7; rs1_data = 64'h77; exp_cur = '0;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Reset while stalled with the skid full.
    out_ready = 1'b0;
    send(2'b01, 3'b000, 1'b0, 1'b0, 64'h81, 64'h8, 64'h0, 5'd8, 64'h8, 4'b0110, 1'b0);
    send(2'b01, 3'b000, 1'b0, 1'b0, 64'h91, 64'h9, 64'h0, 5'd9, 64'h9, 4'b0110, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("mrst_a", a, 64'd0);
    chk("mrst_b", b, 64'd0);
    chk("mrst_ctl", {60'd0, alu_control_signal}, 64'd0);
    chk("mrst_rd", {59'd0, rd_out}, 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2'b10, 3'b100, 1'b0, 1'b0, 64'h55, 64'hAA, 64'h0, 5'd20, 64'hAA, 4'b0100, 1'b0);
    chk("post_rst_latency", {63'd0, out_valid}, 64'd1);
    chk("post_rst_rd", {59'd0, rd_out}, 64'd20);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
